// File: rtl/dz_scan_if.sv
// dz_scan_if: bus bundle between the dz display path and the scan driver.
//   master : upstream logic (drives enable, writes, swap requests, brightness;
//            observes pins and status)
//   slave  : dz_scan itself
// Signals:
//   enable      scan when 1, blank and hold when 0
//   wr_en       back-buffer write strobe
//   wr_row      row index of the write (values >= ROWS are ignored)
//   wr_r/wr_g   red / green bitmap for wr_row
//   swap_req    request a front/back exchange at the next frame boundary
//   brightness  lit cycles per row slot (clamped to DWELL-BLANK)
//   row         active-low one-hot row select
//   colr/colg   active-high red / green columns
//   swap_pend   swap requested but not yet executed
//   frame_start one-cycle pulse when the pins show row 0, slot cycle 0
interface dz_scan_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 16
);
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(DWELL + 1);

  logic            enable;
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_r;
  logic [COLS-1:0] wr_g;
  logic            swap_req;
  logic [BW-1:0]   brightness;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] colr;
  logic [COLS-1:0] colg;
  logic            swap_pend;
  logic            frame_start;

  modport master (
    output enable, wr_en, wr_row, wr_r, wr_g, swap_req, brightness,
    input  row, colr, colg, swap_pend, frame_start
  );

  modport slave (
    input  enable, wr_en, wr_row, wr_r, wr_g, swap_req, brightness,
    output row, colr, colg, swap_pend, frame_start
  );
endinterface

// File: rtl/dz_scan.sv
// dz_scan: double-buffered RGY dot-matrix scan driver.
// Upstream writes row bitmaps into the back buffer and requests a swap; the
// swap is taken at the next frame boundary. The front buffer is scanned row
// by row, each row slot being DWELL cycles long with BLANK dark cycles at the
// start followed by a PWM window of `brightness` lit cycles.
// Ports:
//   clk  scan clock
//   rst  asynchronous active-low reset (clears buffers, blanks pins)
//   bus  dz_scan_if slave modport (see interface header)
// All pins are registered: they show the scan state of the previous cycle.
module dz_scan #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 16,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  dz_scan_if.slave   bus
);
  localparam int RW  = $clog2(ROWS);
  localparam int BW  = $clog2(DWELL + 1);
  localparam int BW1 = BW + 1;
  localparam int RW1 = RW + 1;
  localparam int DW  = $clog2(DWELL);
  localparam int CW  = 2 * COLS;

  localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(DWELL - 1);
  localparam logic [BW-1:0] B_MAX   = BW'(DWELL - BLANK);
  localparam logic [BW:0]   BLANK_W = BW1'(BLANK);

  logic [RW-1:0]   r_q, r_d;
  logic [DW-1:0]   d_q, d_d;
  logic            sel_q, sel_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   buf0_q [ROWS];
  logic [CW-1:0]   buf1_q [ROWS];
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] colr_q, colr_d;
  logic [COLS-1:0] colg_q, colg_d;
  logic            fs_q, fs_d;

  logic            boundary_s;
  logic            lit_s;
  logic            wr_ok_s;
  logic [BW-1:0]   eff_s;
  logic [BW:0]     lim_s;
  logic [BW:0]     d_ext_s;
  logic [CW-1:0]   front_s;

  // Scan sequencing, swap arbitration and next pin values.
  always_comb begin
    // With enable low every cycle is a frame boundary so swaps are not stalled.
    boundary_s = !bus.enable || ((r_q == R_LAST) && (d_q == D_LAST));
    // Widen wr_row by one bit so the range check stays meaningful for any ROWS.
    wr_ok_s    = bus.wr_en && ({1'b0, bus.wr_row} < RW1'(ROWS));
    eff_s      = (bus.brightness > B_MAX) ? B_MAX : bus.brightness;
    lim_s      = BLANK_W + BW1'(eff_s);
    d_ext_s    = BW1'(d_q);
    lit_s      = bus.enable && (d_ext_s >= BLANK_W) && (d_ext_s < lim_s);
    front_s    = sel_q ? buf1_q[r_q] : buf0_q[r_q];

    if (!bus.enable) begin
      r_d = {RW{1'b0}};
      d_d = {DW{1'b0}};
    end else if (d_q == D_LAST) begin
      d_d = {DW{1'b0}};
      r_d = (r_q == R_LAST) ? {RW{1'b0}} : r_q + RW'(1);
    end else begin
      d_d = d_q + DW'(1);
      r_d = r_q;
    end

    // A request coinciding with the boundary is consumed there and never
    // shows as pending; repeated requests collapse into one toggle.
    if (boundary_s && (pend_q || bus.swap_req)) begin
      sel_d  = ~sel_q;
      pend_d = 1'b0;
    end else if (bus.swap_req) begin
      sel_d  = sel_q;
      pend_d = 1'b1;
    end else begin
      sel_d  = sel_q;
      pend_d = pend_q;
    end

    if (lit_s) begin
      row_d  = ~({{(ROWS-1){1'b0}}, 1'b1} << r_q);
      colr_d = front_s[CW-1:COLS];
      colg_d = front_s[COLS-1:0];
    end else begin
      row_d  = {ROWS{1'b1}};
      colr_d = {COLS{1'b0}};
      colg_d = {COLS{1'b0}};
    end

    fs_d = bus.enable && (r_q == {RW{1'b0}}) && (d_q == {DW{1'b0}});
  end

  // Scan counters, buffer select, swap flag and registered pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= {RW{1'b0}};
      d_q    <= {DW{1'b0}};
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
      row_q  <= {ROWS{1'b1}};
      colr_q <= {COLS{1'b0}};
      colg_q <= {COLS{1'b0}};
      fs_q   <= 1'b0;
    end else begin
      r_q    <= r_d;
      d_q    <= d_d;
      sel_q  <= sel_d;
      pend_q <= pend_d;
      row_q  <= row_d;
      colr_q <= colr_d;
      colg_q <= colg_d;
      fs_q   <= fs_d;
    end
  end

  // Frame buffers; writes always target the buffer that is back before any
  // swap taken in the same cycle, so a boundary-cycle write becomes front.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        buf0_q[i] <= {CW{1'b0}};
        buf1_q[i] <= {CW{1'b0}};
      end
    end else if (wr_ok_s) begin
      if (sel_q) begin
        buf0_q[bus.wr_row] <= {bus.wr_r, bus.wr_g};
      end else begin
        buf1_q[bus.wr_row] <= {bus.wr_r, bus.wr_g};
      end
    end
  end

  assign bus.row         = row_q;
  assign bus.colr        = colr_q;
  assign bus.colg        = colg_q;
  assign bus.swap_pend   = pend_q;
  assign bus.frame_start = fs_q;
endmodule
